// File: rtl/buff_uart_tx.sv
// Buffered UART transmitter: FIFO of width-bit words serialised as
// start / data (LSB first) / stop frames, each bit held DIV = clock_freq/baud_rate clocks.
// Optional even-parity bit between data and stop when BUFF_UART_TX_PARITY_EN is defined.
module buff_uart_tx #(
  parameter int width       = 8,
  parameter int fifo_length = 4,
  parameter int baud_rate   = 9600,
  parameter int clock_freq  = 460800
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             write_enable,
  input  logic [width-1:0]                 data,
  output logic                             tx,
  output logic                             full,
  output logic                             empty,
  output logic                             busy,
  output logic [$clog2(fifo_length+1)-1:0] count
);

  localparam int DIV = clock_freq / baud_rate;
  localparam int PW  = $clog2(fifo_length);
  localparam int CW  = $clog2(fifo_length + 1);
  localparam int BW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int IW  = (width > 1) ? $clog2(width) : 1;

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_e;

  state_e           state_q, state_d;
  logic [BW-1:0]    baud_q, baud_d;
  logic [IW-1:0]    bit_q, bit_d;
  logic [width-1:0] shift_q, shift_d;
`ifdef BUFF_UART_TX_PARITY_EN
  logic             par_q, par_d;
`endif

  logic [width-1:0] mem_q [fifo_length];
  logic [PW-1:0]    wptr_q, rptr_q;
  logic [CW-1:0]    count_q;
  logic             push, pop, baud_end;
  logic [width-1:0] head;

  assign full     = (count_q == CW'(fifo_length));
  assign empty    = (count_q == '0);
  assign busy     = (state_q != S_IDLE);
  assign count    = count_q;
  // A write into a full FIFO is dropped even if a pop frees a slot this cycle.
  assign push     = write_enable && !full;
  assign head     = mem_q[rptr_q];
  assign baud_end = (baud_q == BW'(DIV - 1));

  // FIFO storage; contents need no reset since the pointers/count define validity.
  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= data;
  end

  // FIFO pointers and occupancy; pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Frame FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
`ifdef BUFF_UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
`ifdef BUFF_UART_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  // Next-state, pop and line drive; the baud counter restarts on every state entry.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q + 1'b1;
    bit_d   = bit_q;
    shift_d = shift_q;
`ifdef BUFF_UART_TX_PARITY_EN
    par_d   = par_q;
`endif
    pop     = 1'b0;
    tx      = 1'b1;
    case (state_q)
      S_IDLE: begin
        baud_d = '0;
        if (!empty) begin
          pop     = 1'b1;
          shift_d = head;
`ifdef BUFF_UART_TX_PARITY_EN
          par_d   = ^head;
`endif
          state_d = S_START;
        end
      end
      S_START: begin
        tx = 1'b0;
        if (baud_end) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        tx = shift_q[0];
        if (baud_end) begin
          baud_d  = '0;
          shift_d = shift_q >> 1;
          bit_d   = bit_q + 1'b1;
          if (bit_q == IW'(width - 1)) begin
`ifdef BUFF_UART_TX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end
        end
      end
`ifdef BUFF_UART_TX_PARITY_EN
      S_PARITY: begin
        tx = par_q;
        if (baud_end) begin
          baud_d  = '0;
          state_d = S_STOP;
        end
      end
`endif
      S_STOP: begin
        tx = 1'b1;
        if (baud_end) begin
          baud_d = '0;
          // Chain straight into the next frame when words are waiting.
          if (!empty) begin
            pop     = 1'b1;
            shift_d = head;
`ifdef BUFF_UART_TX_PARITY_EN
            par_d   = ^head;
`endif
            state_d = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: begin
        baud_d  = '0;
        state_d = S_IDLE;
      end
    endcase
  end

endmodule
